// File: rtl/jarvis_pkg.sv
// Shared definitions for the fetch front end: datapath width, default reset PC,
// sequencer state encoding and an alignment helper.
package jarvis_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO with push/pop/flush; simultaneous push and pop keeps the count.
module fetch_buf #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [1:0]       count,
  output logic             valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             do_push_s;
  logic             do_pop_s;

  always_comb begin
    do_pop_s  = pop && (count_r != 2'd0);
    do_push_s = push && ((count_r != 2'd2) || do_pop_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      // Stored data is left in place; only the occupancy is discarded.
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r <= do_pop_s ? ~rd_ptr_r : rd_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count     = count_r;
  assign valid     = (count_r != 2'd0);
  assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch address generator feeding a 2-entry instruction buffer.
// Define PC_SEQ_MISALIGN_EN to enable the sticky misaligned-redirect fault and HALT.
module pc_sequencer
  import jarvis_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc_out,
  input  logic [XLEN-1:0] instr_in,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            fault
);

  seq_state_e        state_r, state_next_s;
  logic [XLEN-1:0]   fetch_pc_r, fetch_pc_next_s;
  logic [XLEN-1:0]   inflight_pc_r;
  logic              inflight_r;
  logic              fault_r, fault_next_s;
  logic              issue_s, flush_s, pop_s, push_s, misalign_s;
  logic              buf_valid_s;
  logic [1:0]        count_s;
  logic [2:0]        occupancy_s;
  logic [2*XLEN-1:0] head_s;

`ifdef PC_SEQ_MISALIGN_EN
  assign misalign_s = is_misaligned(redirect_pc);
`else
  assign misalign_s = 1'b0;
`endif

  always_comb begin
    state_next_s    = state_r;
    fetch_pc_next_s = fetch_pc_r;
    fault_next_s    = fault_r;
    issue_s         = 1'b0;
    flush_s         = 1'b0;
    pop_s           = 1'b0;
    occupancy_s     = 3'd0;
    case (state_r)
      BOOT: state_next_s = RUN;
      RUN: begin
        if (redirect_valid) begin
          // Redirect overrides any pop, push or issue in the same cycle.
          flush_s = 1'b1;
          if (misalign_s) begin
            fault_next_s = 1'b1;
            state_next_s = HALT;
          end else begin
            fetch_pc_next_s = redirect_pc;
          end
        end else begin
          pop_s       = buf_valid_s && out_ready;
          occupancy_s = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
          if (occupancy_s < 3'd2) begin
            issue_s         = 1'b1;
            fetch_pc_next_s = fetch_pc_r + PC_STEP;
          end else begin
            issue_s = 1'b0;
          end
        end
      end
      HALT:    flush_s = 1'b1;
      default: state_next_s = BOOT;
    endcase
  end

  assign push_s = inflight_r && !flush_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= BOOT;
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= '0;
      fault_r       <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      fetch_pc_r    <= fetch_pc_next_s;
      inflight_r    <= issue_s;
      inflight_pc_r <= issue_s ? fetch_pc_r : inflight_pc_r;
      fault_r       <= fault_next_s;
    end
  end

  fetch_buf #(.WIDTH(2*XLEN)) u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data ({inflight_pc_r, instr_in}),
    .pop       (pop_s),
    .flush     (flush_s),
    .count     (count_s),
    .valid     (buf_valid_s),
    .head_data (head_s)
  );

  assign pc_out    = fetch_pc_r;
  assign out_valid = buf_valid_s;
  assign out_pc    = head_s[2*XLEN-1:XLEN];
  assign out_instr = head_s[XLEN-1:0];
  assign fault     = fault_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand sequences, random run.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_a, instr_a, out_instr_a, out_pc_a, redir_pc_a;
  logic        redir_a, valid_a, ready_a, fault_a;
  logic [31:0] pc_b, instr_b, out_instr_b, out_pc_b;
  logic        valid_b, fault_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut_a (
    .clk(clk), .rst(rst), .pc_out(pc_a), .instr_in(instr_a),
    .redirect_valid(redir_a), .redirect_pc(redir_pc_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_instr(out_instr_a),
    .out_pc(out_pc_a), .fault(fault_a)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst), .pc_out(pc_b), .instr_in(instr_b),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
    .out_valid(valid_b), .out_ready(1'b1), .out_instr(out_instr_b),
    .out_pc(out_pc_b), .fault(fault_b)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return 32'hA000_0000 + (pc >> 2);
  endfunction

  // Synchronous instruction memory: word for pc_out appears on instr_in next cycle.
  always @(posedge clk) begin
    instr_a <= mem_word(pc_a);
    instr_b <= mem_word(pc_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redir_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_out_pc;
    logic [31:0] exp_pc_out;
    logic        exp_fault;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] eo, input logic [31:0] ep,
                              input logic ef);
    vec_t v;
    v.ready = rdy; v.redir = rv; v.rpc = rpc; v.exp_valid = ev;
    v.exp_out_pc = eo; v.exp_pc_out = ep; v.exp_fault = ef;
    return v;
  endfunction

  vec_t tbl [24];

  initial begin
    logic [31:0] exp_pc;
    logic        redir_prev;
    int          xfers;

    ready_a = 1'b1;
    redir_a = 1'b0;
    redir_pc_a = 32'h0;

    // Cycle-by-cycle table: boot latency, 10-cycle stall, redirect while full, misaligned redirect.
    tbl[0]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h4,   1'b0);
    for (int i = 3; i <= 12; i++) tbl[i] = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h8, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   32'h8,   1'b0);
    tbl[14] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'hC,   1'b0);
    tbl[15] = mk(1'b1, 1'b1, 32'h100, 1'b1, 32'h4,   32'hC,   1'b0);
    tbl[16] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h100, 1'b0);
    tbl[17] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104, 1'b0);
    tbl[18] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 32'h108, 1'b0);
    tbl[19] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 32'h10C, 1'b0);
    tbl[20] = mk(1'b1, 1'b1, 32'h102, 1'b1, 32'h108, 32'h110, 1'b0);
`ifdef PC_SEQ_MISALIGN_EN
    for (int i = 21; i <= 23; i++) tbl[i] = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h110, 1'b1);
`else
    tbl[21] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h102, 1'b0);
    tbl[22] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h106, 1'b0);
    tbl[23] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h102, 32'h10A, 1'b0);
`endif

    do_reset();
    for (int i = 0; i < 24; i++) begin
      check($sformatf("tbl%0d_valid", i), {31'd0, valid_a}, {31'd0, tbl[i].exp_valid});
      check($sformatf("tbl%0d_pc_out", i), pc_a, tbl[i].exp_pc_out);
      check($sformatf("tbl%0d_fault", i), {31'd0, fault_a}, {31'd0, tbl[i].exp_fault});
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl%0d_out_pc", i), out_pc_a, tbl[i].exp_out_pc);
        check($sformatf("tbl%0d_out_instr", i), out_instr_a, mem_word(tbl[i].exp_out_pc));
      end
      ready_a    = tbl[i].ready;
      redir_a    = tbl[i].redir;
      redir_pc_a = tbl[i].rpc;
      next_cycle();
    end
    redir_a = 1'b0;

    // Steady streaming, wrap-around on dut_b, then a stall and an asynchronous reset.
    do_reset();
    ready_a = 1'b1;
    next_cycle();
    next_cycle();
    check("boot_not_early", {31'd0, valid_a}, 32'd0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stream%0d_valid", k), {31'd0, valid_a}, 32'd1);
      check($sformatf("stream%0d_pc", k), out_pc_a, 32'(4 * k));
      check($sformatf("stream%0d_instr", k), out_instr_a, 32'hA000_0000 + 32'(k));
      check($sformatf("wrap%0d_valid", k), {31'd0, valid_b}, 32'd1);
      check($sformatf("wrap%0d_pc", k), out_pc_b, 32'hFFFF_FFF8 + 32'(4 * k));
      check($sformatf("wrap%0d_instr", k), out_instr_b, mem_word(32'hFFFF_FFF8 + 32'(4 * k)));
      next_cycle();
    end
    check("wrap_fault", {31'd0, fault_b}, 32'd0);
    ready_a = 1'b0;
    repeat (2) next_cycle();
    check("stall_valid", {31'd0, valid_a}, 32'd1);
    check("stall_head", out_pc_a, 32'h10);
    check("stall_pc_out", pc_a, 32'h18);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, valid_a}, 32'd0);
    check("async_rst_out_pc", out_pc_a, 32'd0);
    check("async_rst_out_instr", out_instr_a, 32'd0);
    check("async_rst_pc_out", pc_a, 32'd0);
    do_reset();
    ready_a = 1'b1;
    repeat (2) next_cycle();
    check("restart_not_early", {31'd0, valid_a}, 32'd0);
    next_cycle();
    check("restart_valid", {31'd0, valid_a}, 32'd1);
    check("restart_pc", out_pc_a, 32'd0);

    // Random run against an ordered-stream model: delivered pcs step by 4, restarting at each redirect target.
    do_reset();
    exp_pc = 32'h0;
    redir_prev = 1'b0;
    xfers = 0;
    for (int c = 0; c < 600; c++) begin
      if (redir_prev) check($sformatf("rand%0d_flush", c), {31'd0, valid_a}, 32'd0);
      ready_a    = ($urandom_range(0, 3) != 0);
      redir_a    = (c >= 2) && ($urandom_range(0, 19) == 0);
      redir_pc_a = $urandom & 32'h0000_0FFC;
      if (redir_a) begin
        exp_pc = redir_pc_a;
      end else if (valid_a && ready_a) begin
        check($sformatf("rand%0d_pc", c), out_pc_a, exp_pc);
        check($sformatf("rand%0d_instr", c), out_instr_a, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        xfers++;
      end
      redir_prev = redir_a;
      next_cycle();
    end
    redir_a = 1'b0;
    check("rand_progress", {31'd0, (xfers > 100)}, 32'd1);
    check("rand_fault", {31'd0, fault_a}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter PC_STEP, default 4, address increment per sequential fetch.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pc_out  output  32  address driven to instr_fetch pc.
REQ-006 SHALL have port instr_in  input  32  instr_fetch instr_out; valid one cycle after the matching pc_out.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump request.
REQ-008 SHALL have port redirect_pc  input  32  redirect target.
REQ-009 SHALL have port out_valid  output  1  buffered instruction available to decode.
REQ-010 SHALL have port out_ready  input  1  decode accepts; transfer when out_valid && out_ready.
REQ-011 SHALL have port out_instr  output  32  instruction at buffer head.
REQ-012 SHALL have port out_pc  output  32  address of out_instr.
REQ-013 SHALL have port fault  output  1  misaligned-redirect fault (see Configuration).

Function
REQ-014 SHALL implement states BOOT, RUN, HALT; BOOT -> RUN after one cycle; RUN -> HALT only on fault; HALT exits only via rst.
REQ-015 SHALL hold a fetch_pc register driven onto pc_out; an "issue" in cycle t marks one fetch in flight whose instr_in is captured at the end of cycle t+1.
REQ-016 SHALL issue in RUN only when buffer_count + inflight < 2 (after accounting for a same-cycle pop); on issue fetch_pc += PC_STEP, modulo 2^32 (wrap 32'hFFFF_FFFC -> 0 silently).
REQ-017 SHALL keep a 2-entry FIFO of {pc, instr}; out_valid = count != 0; out_instr/out_pc = head entry.
REQ-018 SHALL allow simultaneous push (returning fetch) and pop in one cycle with count unchanged.
REQ-019 SHALL never overflow the FIFO; stalled out_ready holds pc_out stable and out_* stable.
REQ-020 SHALL, on redirect_valid in RUN: flush the FIFO, discard the in-flight fetch, load fetch_pc <= redirect_pc, no issue that cycle; redirect wins over a simultaneous push, pop or issue.
REQ-021 SHALL deassert out_valid the cycle after a redirect; the first target instruction appears on out_* 3 cycles after the redirect cycle.
REQ-022 SHALL ignore redirect_valid in BOOT and HALT.
REQ-023 SHALL stop issuing and hold out_valid low in HALT.

Reset
REQ-024 SHALL on rst asynchronously set: state BOOT, fetch_pc = RESET_PC, count 0, inflight 0, fault 0, out_valid 0, out_instr 0, out_pc 0.
REQ-025 SHALL on rst mid-operation drop all buffered and in-flight instructions; first out_valid 4 cycles after rst deassert.

Configuration
REQ-026 SHALL with PC_SEQ_MISALIGN_EN defined: redirect_pc[1:0] != 0 on an accepted redirect sets fault = 1 (sticky), flushes as REQ-020, enters HALT.
REQ-027 SHALL without PC_SEQ_MISALIGN_EN: fault tied 0, HALT unreachable, misaligned targets fetched unchanged.

Structure
REQ-028 SHALL place state enum (BOOT/RUN/HALT), XLEN = 32 and the default RESET_PC in shared package jarvis_pkg.
REQ-029 SHALL implement the 2-entry buffer as sub-module fetch_buf (parameterised width, push/pop/flush, count).

Verification
REQ-030 Reset then out_ready=1 steady, memory word k = 32'hA000_0000+k -> out_pc 0,4,8,12 with out_instr A0000000,A0000001,... one per cycle after first out_valid at cycle 4.
REQ-031 out_ready=0 for 10 cycles after first valid -> FIFO holds 2 entries (pc 0,4), pc_out stuck at 8, no entry lost when out_ready returns to 1.
REQ-032 redirect_valid with redirect_pc=32'h0000_0100 while FIFO full -> out_valid low next cycle, next accepted out_pc = 0x100 exactly 3 cycles after redirect, no stale pc 0x8 delivered.
REQ-033 RESET_PC=32'hFFFF_FFF8 -> out_pc sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-034 PC_SEQ_MISALIGN_EN: redirect_pc=32'h0000_0102 -> fault=1 next cycle, out_valid stays 0, pc_out frozen until rst; macro undefined: same stimulus -> fault=0, out_pc=0x102 delivered.
REQ-035 rst asserted mid-stream with 2 buffered entries -> out_valid 0 immediately (asynchronous), sequence restarts at RESET_PC.
